// File: rtl/gpio_in_capture_if.sv
// Signal bundle between the GPIO peripheral (master) and the pin input capture block (slave).
// No handshake: every field is a level, except clr, which is a one-cycle write-1-to-clear strobe.
interface gpio_in_capture_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] pin_in;
    logic [WIDTH-1:0] iosel;
    logic             db_en;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] pending;
    logic             irq;

    modport master (
        output pin_in, iosel, db_en, rise_en, fall_en, clr,
        input  level, pending, irq
    );

    modport slave (
        input  pin_in, iosel, db_en, rise_en, fall_en, clr,
        output level, pending, irq
    );
endinterface

// File: rtl/gpio_in_capture.sv
// GPIO input capture: per-bit synchronizer, optional debounce filter, and edge detection
// into sticky write-1-to-clear pending flags with an OR-reduced interrupt.
module gpio_in_capture #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    gpio_in_capture_if.slave  bus
);
    localparam int            CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [CW-1:0]    r_cnt  [WIDTH];
    logic [CW-1:0]    w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_level_nxt;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_pending_nxt;

    // Only the first stage of the chain samples the asynchronous pad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= bus.pin_in;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // The counter saturates by compare; it restarts whenever s agrees with level or the filter is bypassed.
    always_comb begin
        w_level_nxt = r_level;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (!bus.db_en) begin
                w_level_nxt[i] = w_s[i];
            end else if (w_s[i] != r_level[i]) begin
                if (r_cnt[i] == CNT_MAX) w_level_nxt[i] = w_s[i];
                else                     w_cnt_nxt[i]   = r_cnt[i] + CW'(1);
            end
        end
    end

    // Events come from the next/current level pair so pending sets on the same edge level moves.
    assign w_rise        =  w_level_nxt & ~r_level & bus.rise_en & ~bus.iosel;
    assign w_fall        = ~w_level_nxt &  r_level & bus.fall_en & ~bus.iosel;
    assign w_pending_nxt = (r_pending & ~bus.clr) | w_rise | w_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= '0;
            r_pending <= '0;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            r_level   <= w_level_nxt;
            r_pending <= w_pending_nxt;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_nxt[i];
        end
    end

    assign bus.level   = r_level;
    assign bus.pending = r_pending;
    assign bus.irq     = |r_pending;
endmodule

// File: tb/tb_gpio_in_capture.sv
// Directed bench for gpio_in_capture (WIDTH=8, SYNC_STAGES=2, DB_CYCLES=4): a vector table
// for bypass-mode behaviour plus hand-written sequences for latency, debounce, collision and reset.
module tb_gpio_in_capture;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    gpio_in_capture_if #(.WIDTH(8)) bus ();

    gpio_in_capture #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .DB_CYCLES   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pin;
        logic [7:0] iosel;
        logic [7:0] rise_en;
        logic [7:0] fall_en;
        logic [7:0] clr;
        logic [7:0] exp_level;
        logic [7:0] exp_pending;
    } vec_t;

    vec_t vecs [0:16];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_all(input string name, input logic [7:0] lvl, input logic [7:0] pend);
        check({name, ".level"},   bus.level,   lvl);
        check({name, ".pending"}, bus.pending, pend);
        check({name, ".irq"},     {7'd0, bus.irq}, {7'd0, |pend});
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        // pin, iosel, rise_en, fall_en, clr, exp_level, exp_pending; each row held 3 clocks, bypass mode
        vecs[0]  = {8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h01};
        vecs[1]  = {8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01};
        vecs[2]  = {8'h00, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00};
        vecs[3]  = {8'h80, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'h80};
        vecs[4]  = {8'h80, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h00};
        vecs[5]  = {8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h81};
        vecs[6]  = {8'h01, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00};
        vecs[7]  = {8'h21, 8'h20, 8'hFF, 8'hFF, 8'h00, 8'h21, 8'h00};
        vecs[8]  = {8'h01, 8'h20, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h00};
        vecs[9]  = {8'h21, 8'h20, 8'hFF, 8'hFF, 8'h00, 8'h21, 8'h00};
        vecs[10] = {8'h21, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h21, 8'h00};
        vecs[11] = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[12] = {8'h0C, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h0C, 8'h0C};
        vecs[13] = {8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h0C};
        vecs[14] = {8'h00, 8'h00, 8'hFF, 8'h00, 8'h04, 8'h00, 8'h08};
        vecs[15] = {8'h00, 8'h00, 8'hFF, 8'h00, 8'h04, 8'h00, 8'h08};
        vecs[16] = {8'h00, 8'h00, 8'hFF, 8'h00, 8'h08, 8'h00, 8'h00};

        // Reset with a guaranteed falling edge on rst_n
        rst_n       = 1'b1;
        bus.pin_in  = '0;
        bus.iosel   = '0;
        bus.db_en   = 1'b0;
        bus.rise_en = '0;
        bus.fall_en = '0;
        bus.clr     = '0;
        #1 rst_n = 1'b0;
        #11;
        check_all("reset", 8'h00, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        step(3);
        check_all("post_reset", 8'h00, 8'h00);

        // Bypass rising edge: visible after edge k+2, not k+1
        bus.rise_en = 8'h01;
        bus.pin_in  = 8'h01;
        step(2);
        check_all("bypass_k1", 8'h00, 8'h00);
        step(1);
        check_all("bypass_k2", 8'h01, 8'h01);
        bus.clr = 8'h01;
        step(1);
        bus.clr = '0;
        check_all("bypass_clr", 8'h01, 8'h00);
        bus.pin_in = 8'h00;
        step(3);
        check_all("bypass_fall_dis", 8'h00, 8'h00);

        for (int v = 0; v <= 16; v++) begin
            bus.pin_in  = vecs[v].pin;
            bus.iosel   = vecs[v].iosel;
            bus.rise_en = vecs[v].rise_en;
            bus.fall_en = vecs[v].fall_en;
            bus.clr     = vecs[v].clr;
            step(3);
            bus.clr = '0;
            check_all($sformatf("vec%0d", v), vecs[v].exp_level, vecs[v].exp_pending);
        end

        // Set/clear collision on bit 3
        bus.rise_en = 8'h08;
        bus.fall_en = 8'h00;
        bus.pin_in  = 8'h08;
        step(3);
        check_all("coll_set", 8'h08, 8'h08);
        bus.pin_in = 8'h00;
        step(3);
        check_all("coll_low", 8'h00, 8'h08);
        bus.pin_in = 8'h08;
        step(2);
        bus.clr = 8'h08;
        step(1);
        bus.clr = '0;
        check_all("coll_setwins", 8'h08, 8'h08);
        bus.clr = 8'h08;
        step(1);
        bus.clr = '0;
        check_all("coll_clr", 8'h08, 8'h00);
        bus.pin_in = 8'h00;
        step(3);

        // Debounce: 3-clock glitch filtered, held pulse accepted at k+5
        bus.db_en   = 1'b1;
        bus.rise_en = 8'h04;
        bus.fall_en = 8'h00;
        bus.pin_in  = 8'h04;
        step(3);
        bus.pin_in = 8'h00;
        step(8);
        check_all("db_glitch", 8'h00, 8'h00);
        bus.pin_in = 8'h04;
        step(5);
        check_all("db_k4", 8'h00, 8'h00);
        step(1);
        check_all("db_k5", 8'h04, 8'h04);
        bus.clr = 8'h04;
        step(1);
        bus.clr = '0;
        check_all("db_clr", 8'h04, 8'h00);
        bus.pin_in = 8'h00;
        step(8);
        check_all("db_fall_dis", 8'h00, 8'h00);

        // Reset mid-debounce with pending set, then release with pin 1 high
        bus.pin_in = 8'h04;
        step(6);
        check_all("pre_rst", 8'h04, 8'h04);
        bus.pin_in = 8'h02;
        step(3);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 8'h00, 8'h00);
        bus.db_en   = 1'b0;
        bus.rise_en = 8'h02;
        @(negedge clk) rst_n = 1'b1;
        step(2);
        check_all("rel_k1", 8'h00, 8'h00);
        step(1);
        check_all("rel_k2", 8'h02, 8'h02);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
